noc_vc_credit_tracker: RTL and testbench

- Tracks downstream buffer credits and packet ownership for every virtual channel of one router output port.
- Produces the per-VC `vc_ready` vector consumed by the port/VC arbitration stage, and the per-VC flit-level `flit_ok` flags consumed by the switch-traversal stage.
- Sits between the output side of the crossbar and the link to the neighbouring router, whose input FIFOs return credits.

---
 rtl/noc_vc_credit_tracker_pkg.sv | 14 +
 rtl/noc_vc_credit_tracker_if.sv | 25 ++
 rtl/noc_vc_credit_counter.sv | 106 ++++++++++
 rtl/noc_vc_credit_tracker.sv | 33 +++
 tb/tb_noc_vc_credit_tracker.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/noc_vc_credit_tracker_pkg.sv
// Shared types and defaults for the per-port virtual-channel credit tracker.
package noc_vc_credit_tracker_pkg;

    localparam int Noc_VC_Channel = 2;
    localparam int Noc_VC_Depth   = 4;

    typedef logic [$clog2(Noc_VC_Depth+1)-1:0] noc_credit_t;

    typedef enum logic {
        VC_IDLE = 1'b0,
        VC_BUSY = 1'b1
    } noc_vc_state_e;

endpackage

// File: rtl/noc_vc_credit_tracker_if.sv
// Flit/credit handshake between the crossbar output, the link and the tracker.
interface noc_vc_credit_tracker_if #(
    parameter int CHANNELS = 2,
    parameter int CW       = 3
);
    logic [CHANNELS-1:0]         flit_send;
    logic                        flit_head;
    logic                        flit_tail;
    logic [CHANNELS-1:0]         credit_return;
    logic [CHANNELS-1:0]         vc_ready;
    logic [CHANNELS-1:0]         flit_ok;
    logic [CHANNELS-1:0][CW-1:0] credit_count;
    logic [CHANNELS-1:0]         err_overflow;
    logic [CHANNELS-1:0]         err_underflow;

    modport master (
        output flit_send, flit_head, flit_tail, credit_return,
        input  vc_ready, flit_ok, credit_count, err_overflow, err_underflow
    );

    modport slave (
        input  flit_send, flit_head, flit_tail, credit_return,
        output vc_ready, flit_ok, credit_count, err_overflow, err_underflow
    );
endinterface

// File: rtl/noc_vc_credit_counter.sv
// One virtual channel: saturating credit counter, packet ownership FSM, sticky errors.
module noc_vc_credit_counter
    import noc_vc_credit_tracker_pkg::*;
#(
    parameter int DEPTH     = Noc_VC_Depth,
    parameter int THRESHOLD = 1,
    localparam int CW       = $clog2(DEPTH+1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          send_i,
    input  logic          head_i,
    input  logic          tail_i,
    input  logic          return_i,
    output logic          vc_ready_o,
    output logic          flit_ok_o,
    output logic [CW-1:0] count_o,
    output logic          err_overflow_o,
    output logic          err_underflow_o
);

    logic [CW-1:0] count_q, count_d;
    noc_vc_state_e state_q, state_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          vc_ready_q, vc_ready_d;
    logic          flit_ok_q, flit_ok_d;

    // Next-state: counter, ownership and outputs decoded from the next state
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        state_d = state_q;

        // A simultaneous send and return cancel out and never flag an error
        case ({send_i, return_i})
            2'b10: begin
                if (count_q == {CW{1'b0}}) begin
                    unf_d = 1'b1;
                end else begin
                    count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
                end
            end
            2'b01: begin
                if (count_q == CW'(DEPTH)) begin
                    ovf_d = 1'b1;
                end else begin
                    count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase

        case (state_q)
            VC_IDLE: begin
                if (send_i && head_i && !tail_i) begin
                    state_d = VC_BUSY;
                end else begin
                    state_d = VC_IDLE;
                end
            end
            VC_BUSY: begin
                if (send_i && tail_i) begin
                    state_d = VC_IDLE;
                end else begin
                    state_d = VC_BUSY;
                end
            end
            default: begin
                state_d = VC_IDLE;
            end
        endcase

        vc_ready_d = (state_d == VC_IDLE) && (count_d >= CW'(THRESHOLD));
        flit_ok_d  = (count_d != {CW{1'b0}});
    end

    // State and output registers; reset restores full credit and idle ownership
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= CW'(DEPTH);
            state_q    <= VC_IDLE;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            vc_ready_q <= 1'b1;
            flit_ok_q  <= 1'b1;
        end else begin
            count_q    <= count_d;
            state_q    <= state_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            vc_ready_q <= vc_ready_d;
            flit_ok_q  <= flit_ok_d;
        end
    end

    assign vc_ready_o      = vc_ready_q;
    assign flit_ok_o       = flit_ok_q;
    assign count_o         = count_q;
    assign err_overflow_o  = ovf_q;
    assign err_underflow_o = unf_q;

endmodule

// File: rtl/noc_vc_credit_tracker.sv
// Output-port credit tracker: one credit counter per virtual channel, shared head/tail qualifiers.
module noc_vc_credit_tracker
    import noc_vc_credit_tracker_pkg::*;
#(
    parameter int CHANNELS  = Noc_VC_Channel,
    parameter int DEPTH     = Noc_VC_Depth,
    parameter int THRESHOLD = 1
) (
    input  logic                    noc_clk,
    input  logic                    noc_rst_n,
    noc_vc_credit_tracker_if.slave  bus
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_vc
        noc_vc_credit_counter #(
            .DEPTH     (DEPTH),
            .THRESHOLD (THRESHOLD)
        ) u_counter (
            .clk             (noc_clk),
            .rst_n           (noc_rst_n),
            .send_i          (bus.flit_send[i]),
            .head_i          (bus.flit_head),
            .tail_i          (bus.flit_tail),
            .return_i        (bus.credit_return[i]),
            .vc_ready_o      (bus.vc_ready[i]),
            .flit_ok_o       (bus.flit_ok[i]),
            .count_o         (bus.credit_count[i]),
            .err_overflow_o  (bus.err_overflow[i]),
            .err_underflow_o (bus.err_underflow[i])
        );
    end

endmodule

// File: tb/tb_noc_vc_credit_tracker.sv
// Directed-vector scoreboard bench: two trackers (THRESHOLD 1 and 2) share one stimulus stream.
module tb_noc_vc_credit_tracker;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    event sample_ev;

    noc_vc_credit_tracker_if #(.CHANNELS(2), .CW(3)) bus ();
    noc_vc_credit_tracker_if #(.CHANNELS(2), .CW(3)) bus2 ();

    assign bus2.flit_send     = bus.flit_send;
    assign bus2.flit_head     = bus.flit_head;
    assign bus2.flit_tail     = bus.flit_tail;
    assign bus2.credit_return = bus.credit_return;

    noc_vc_credit_tracker #(.CHANNELS(2), .DEPTH(4), .THRESHOLD(1)) dut (
        .noc_clk   (clk),
        .noc_rst_n (rst_n),
        .bus       (bus.slave)
    );

    noc_vc_credit_tracker #(.CHANNELS(2), .DEPTH(4), .THRESHOLD(2)) dut2 (
        .noc_clk   (clk),
        .noc_rst_n (rst_n),
        .bus       (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] c0;
        logic [2:0] c1;
        logic [1:0] vr;
        logic [1:0] vr2;
        logic [1:0] fok;
        logic [1:0] ovf;
        logic [1:0] unf;
        string      nm;
    } exp_t;

    exp_t sb_q[$];

    // flit_send must never be multi-hot
    always @(posedge clk) begin
        if (rst_n) begin
            assert ($countones(bus.flit_send) <= 1)
            else $error("FAIL onehot_send act=%b req=one-hot-or-zero", bus.flit_send);
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s act=%0h req=%0h", nm, act, req);
        end
    endtask

    // Monitor: after each clock edge (or an asynchronous sample request) pop one expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or sample_ev);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk({e.nm, ".cnt0"}, 8'(bus.credit_count[0]), 8'(e.c0));
                chk({e.nm, ".cnt1"}, 8'(bus.credit_count[1]), 8'(e.c1));
                chk({e.nm, ".vc_ready"}, 8'(bus.vc_ready), 8'(e.vr));
                chk({e.nm, ".vc_ready_t2"}, 8'(bus2.vc_ready), 8'(e.vr2));
                chk({e.nm, ".flit_ok"}, 8'(bus.flit_ok), 8'(e.fok));
                chk({e.nm, ".err_ovf"}, 8'(bus.err_overflow), 8'(e.ovf));
                chk({e.nm, ".err_unf"}, 8'(bus.err_underflow), 8'(e.unf));
            end
        end
    end

    function automatic exp_t mk(input logic [2:0] c0, input logic [2:0] c1,
                                input logic [1:0] vr, input logic [1:0] vr2,
                                input logic [1:0] fok, input logic [1:0] ovf,
                                input logic [1:0] unf, input string nm);
        exp_t e;
        e.c0 = c0; e.c1 = c1; e.vr = vr; e.vr2 = vr2;
        e.fok = fok; e.ovf = ovf; e.unf = unf; e.nm = nm;
        return e;
    endfunction

    // Drive one cycle of stimulus and queue the outputs expected after the next edge
    task automatic apply(input logic [1:0] s, input logic h, input logic t, input logic [1:0] r,
                         input logic [2:0] c0, input logic [2:0] c1,
                         input logic [1:0] vr, input logic [1:0] vr2, input logic [1:0] fok,
                         input logic [1:0] ovf, input logic [1:0] unf, input string nm);
        @(negedge clk);
        bus.flit_send     = s;
        bus.flit_head     = h;
        bus.flit_tail     = t;
        bus.credit_return = r;
        sb_q.push_back(mk(c0, c1, vr, vr2, fok, ovf, unf, nm));
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.flit_send     = 2'b00;
        bus.flit_head     = 1'b0;
        bus.flit_tail     = 1'b0;
        bus.credit_return = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        //     send   h     t     ret    c0    c1    vr     vr2    fok    ovf    unf
        apply(2'b00, 1'b0, 1'b0, 2'b00, 3'd4, 3'd4, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, "reset");
        // four-flit packet on VC0
        apply(2'b01, 1'b1, 1'b0, 2'b00, 3'd3, 3'd4, 2'b10, 2'b10, 2'b11, 2'b00, 2'b00, "pkt_head");
        apply(2'b01, 1'b0, 1'b0, 2'b00, 3'd2, 3'd4, 2'b10, 2'b10, 2'b11, 2'b00, 2'b00, "pkt_body1");
        apply(2'b01, 1'b0, 1'b0, 2'b00, 3'd1, 3'd4, 2'b10, 2'b10, 2'b11, 2'b00, 2'b00, "pkt_body2");
        apply(2'b01, 1'b0, 1'b1, 2'b00, 3'd0, 3'd4, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, "pkt_tail");
        // credit returns: threshold 1 ready after one, threshold 2 after two
        apply(2'b00, 1'b0, 1'b0, 2'b01, 3'd1, 3'd4, 2'b11, 2'b10, 2'b11, 2'b00, 2'b00, "ret1");
        apply(2'b00, 1'b0, 1'b0, 2'b01, 3'd2, 3'd4, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, "ret2");
        // send+return at full count on VC1
        apply(2'b10, 1'b1, 1'b1, 2'b10, 3'd2, 3'd4, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, "sr_full");
        // drain VC1 with single-flit packets
        apply(2'b10, 1'b1, 1'b1, 2'b00, 3'd2, 3'd3, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, "drain3");
        apply(2'b10, 1'b1, 1'b1, 2'b00, 3'd2, 3'd2, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, "drain2");
        apply(2'b10, 1'b1, 1'b1, 2'b00, 3'd2, 3'd1, 2'b11, 2'b01, 2'b11, 2'b00, 2'b00, "drain1");
        apply(2'b10, 1'b1, 1'b1, 2'b00, 3'd2, 3'd0, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, "drain0");
        // send+return at empty count on VC1
        apply(2'b10, 1'b1, 1'b1, 2'b10, 3'd2, 3'd0, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, "sr_empty");
        // refill VC1
        apply(2'b00, 1'b0, 1'b0, 2'b10, 3'd2, 3'd1, 2'b11, 2'b01, 2'b11, 2'b00, 2'b00, "refill1");
        apply(2'b00, 1'b0, 1'b0, 2'b10, 3'd2, 3'd2, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, "refill2");
        apply(2'b00, 1'b0, 1'b0, 2'b10, 3'd2, 3'd3, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, "refill3");
        apply(2'b00, 1'b0, 1'b0, 2'b10, 3'd2, 3'd4, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, "refill4");
        // overflow on VC1
        apply(2'b00, 1'b0, 1'b0, 2'b10, 3'd2, 3'd4, 2'b11, 2'b11, 2'b11, 2'b10, 2'b00, "overflow");
        // drain VC0 then underflow
        apply(2'b01, 1'b1, 1'b1, 2'b00, 3'd1, 3'd4, 2'b11, 2'b10, 2'b11, 2'b10, 2'b00, "vc0_d1");
        apply(2'b01, 1'b1, 1'b1, 2'b00, 3'd0, 3'd4, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, "vc0_d0");
        apply(2'b01, 1'b1, 1'b1, 2'b00, 3'd0, 3'd4, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, "underflow");
        apply(2'b00, 1'b0, 1'b0, 2'b00, 3'd0, 3'd4, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, "sticky");
        // build VC0 up to 3, then open a packet: BUSY with count 2
        apply(2'b00, 1'b0, 1'b0, 2'b01, 3'd1, 3'd4, 2'b11, 2'b10, 2'b11, 2'b10, 2'b01, "pre_r1");
        apply(2'b00, 1'b0, 1'b0, 2'b01, 3'd2, 3'd4, 2'b11, 2'b11, 2'b11, 2'b10, 2'b01, "pre_r2");
        apply(2'b00, 1'b0, 1'b0, 2'b01, 3'd3, 3'd4, 2'b11, 2'b11, 2'b11, 2'b10, 2'b01, "pre_r3");
        apply(2'b01, 1'b1, 1'b0, 2'b00, 3'd2, 3'd4, 2'b10, 2'b10, 2'b11, 2'b10, 2'b01, "busy_head");

        // asynchronous reset mid-packet, sampled before any clock edge
        @(negedge clk);
        bus.flit_send     = 2'b00;
        bus.flit_head     = 1'b0;
        bus.flit_tail     = 1'b0;
        bus.credit_return = 2'b00;
        #2;
        rst_n = 1'b0;
        sb_q.push_back(mk(3'd4, 3'd4, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, "async_rst"));
        -> sample_ev;
        @(negedge clk);
        rst_n = 1'b1;
        apply(2'b00, 1'b0, 1'b0, 2'b00, 3'd4, 3'd4, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, "post_rst");
        apply(2'b01, 1'b1, 1'b0, 2'b00, 3'd3, 3'd4, 2'b10, 2'b10, 2'b11, 2'b00, 2'b00, "post_head");
        apply(2'b00, 1'b0, 1'b0, 2'b00, 3'd3, 3'd4, 2'b10, 2'b10, 2'b11, 2'b00, 2'b00, "post_idle");

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain act=%0d req=0 pending expectations", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
